// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order fetches and buffers the
// returned instructions in a small queue that doubles as the IF/ID register.
module if_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            id_stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_instr,
  output logic [6:0]      if_id_opcode
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] rsp_pc_q;
  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [XLEN-1:0] q_instr [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;

  logic [CW:0]     inflight;
  logic            handshake;
  logic            rsp_take;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] redirect_target;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Requests are capped so every in-flight response is guaranteed a queue slot.
  assign inflight        = {1'b0, outstanding} + {1'b0, count};
  assign imem_req_valid  = rst_n && !redirect_valid && (inflight < (CW+1)'(DEPTH));
  assign imem_req_addr   = pc_q;
  assign handshake       = imem_req_valid && imem_req_ready;
  assign rsp_take        = imem_rsp_valid && (outstanding != '0);
  assign push            = !redirect_valid && rsp_take && (drop_cnt == '0);
  assign pop             = !redirect_valid && (count != '0) && !id_stall;
  assign redirect_target = redirect_pc & ~XLEN'(3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      rsp_pc_q    <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(handshake) - CW'(rsp_take);
      if (redirect_valid) begin
        // Everything still in flight belongs to the old path and must be discarded.
        pc_q     <= redirect_target;
        rsp_pc_q <= redirect_target;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        drop_cnt <= outstanding - CW'(rsp_take);
      end else begin
        if (handshake) begin
          pc_q <= pc_q + XLEN'(4);
        end
        if (rsp_take && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
        if (push) begin
          wr_ptr   <= next_ptr(wr_ptr);
          rsp_pc_q <= rsp_pc_q + XLEN'(4);
        end
        if (pop) begin
          rd_ptr <= next_ptr(rd_ptr);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]    <= rsp_pc_q;
      q_instr[wr_ptr] <= imem_rsp_data;
    end
  end

  // An empty queue presents zeros so decode sees every control inactive.
  always_comb begin
    if_id_valid  = (count != '0);
    if_id_pc     = '0;
    if_id_instr  = '0;
    if_id_opcode = '0;
    if (if_id_valid) begin
      if_id_pc     = q_pc[rd_ptr];
      if_id_instr  = q_instr[rd_ptr];
      if_id_opcode = q_instr[rd_ptr][6:0];
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a queue-based fetch model plus an in-order memory model
// with per-request latency, driven by directed scenarios and random traffic.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        id_stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic [6:0]  if_id_opcode;

  if_stage #(.XLEN(32), .RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .id_stall(id_stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
    .if_id_instr(if_id_instr), .if_id_opcode(if_id_opcode)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          due;
  } mreq_t;

  entry_t      mq[$];
  mreq_t       pend[$];
  logic [31:0] m_pc, m_rsp_pc;
  int          m_out, m_drop;
  int          cyc;
  int          checks, errors;

  logic        st_stall, st_ready, st_redir;
  logic [31:0] st_rpc;
  int          lat_lo, lat_hi;
  bit          rand_data;

  logic [104:0] dut_vec;
  assign dut_vec = {imem_req_valid, (imem_req_valid ? imem_req_addr : 32'h0),
                    if_id_valid, if_id_pc, if_id_instr, if_id_opcode};

  function automatic logic model_req_valid();
    return rst_n && !st_redir && ((m_out + mq.size()) < 2);
  endfunction

  function automatic logic [104:0] exp_vec();
    logic        rv;
    logic [31:0] a, p, i;
    rv = model_req_valid();
    a  = rv ? m_pc : 32'h0;
    p  = '0;
    i  = '0;
    if (mq.size() > 0) begin
      p = mq[0].pc;
      i = mq[0].instr;
    end
    return {rv, a, (mq.size() > 0), p, i, i[6:0]};
  endfunction

  task automatic model_reset();
    mq.delete();
    pend.delete();
    m_out    = 0;
    m_drop   = 0;
    m_pc     = RESET_PC;
    m_rsp_pc = RESET_PC;
  endtask

  // Drive this cycle's inputs (memory response included) and let them settle.
  task automatic drive();
    imem_req_ready = st_ready;
    id_stall       = st_stall;
    redirect_valid = st_redir;
    redirect_pc    = st_rpc;
    if (rst_n && pend.size() > 0 && pend[0].due <= cyc + 1) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = pend[0].data;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom();
    end
    #1;
  endtask

  // Apply the fetch rules to the model for the upcoming edge, then clock.
  task automatic advance();
    bit          rsp, hs;
    int          lat;
    logic [31:0] d;
    hs  = model_req_valid() && st_ready;
    rsp = imem_rsp_valid && (m_out > 0);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (rsp) void'(pend.pop_front());
      if (st_redir) begin
        mq.delete();
        if (rsp) m_out--;
        m_drop   = m_out;
        m_pc     = st_rpc & ~32'h3;
        m_rsp_pc = st_rpc & ~32'h3;
      end else begin
        if (mq.size() > 0 && !st_stall) void'(mq.pop_front());
        if (rsp) begin
          m_out--;
          if (m_drop > 0) m_drop--;
          else begin
            mq.push_back('{pc: m_rsp_pc, instr: imem_rsp_data});
            m_rsp_pc += 32'd4;
          end
        end
        if (hs) begin
          lat = $urandom_range(lat_hi, lat_lo);
          d   = rand_data ? $urandom() : (m_pc | 32'h13);
          pend.push_back('{addr: m_pc, data: d, due: cyc + 1 + lat});
          m_out++;
          m_pc += 32'd4;
        end
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic quiet(input int lat);
    st_stall  = 1'b0;
    st_ready  = 1'b1;
    st_redir  = 1'b0;
    st_rpc    = '0;
    lat_lo    = lat;
    lat_hi    = lat;
    rand_data = 1'b0;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    model_reset();
    drive();
    advance();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    quiet(1);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      drive();
      checks++;
      if (dut_vec !== 105'h0) begin
        errors++;
        $display("[TB] FAIL reset cyc=%0d got=%h exp=0", cyc, dut_vec);
      end
      advance();
    end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    quiet(1);
    for (int k = 0; k < 20; k++) begin
      drive();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL stream cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_stall();
    quiet(1);
    for (int k = 0; k < 18; k++) begin
      st_stall = (k >= 3 && k < 8);
      drive();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL stall cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_not_ready();
    quiet(1);
    for (int k = 0; k < 12; k++) begin
      st_ready = !(k >= 2 && k < 5);
      drive();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL not_ready cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_redirect();
    int n;
    quiet(3);
    reset_pulse();
    n = 0;
    while (m_out < 2 && n < 10) begin
      drive();
      advance();
      n++;
    end
    checks++;
    if (m_out < 2) begin
      errors++;
      $display("[TB] FAIL redirect_setup outstanding got=%0d exp=2", m_out);
    end
    st_redir = 1'b1;
    st_rpc   = 32'h100;
    drive();
    advance();
    st_redir = 1'b0;
    n = 0;
    while (!if_id_valid && n < 12) begin
      drive();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL redirect cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      end
      advance();
      n++;
    end
    checks++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'h100) begin
      errors++;
      $display("[TB] FAIL redirect_first valid=%b pc=%h exp pc=00000100", if_id_valid, if_id_pc);
    end
    for (int k = 0; k < 8; k++) begin
      drive();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL redirect_tail cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_redirect_stall_rsp();
    int n;
    quiet(3);
    st_stall = 1'b1;
    n = 0;
    while (!(mq.size() > 0 && pend.size() > 0 && pend[0].due <= cyc + 1) && n < 20) begin
      drive();
      advance();
      n++;
    end
    st_redir = 1'b1;
    st_rpc   = 32'h203;
    drive();
    checks++;
    if (imem_rsp_valid !== 1'b1 || dut_vec !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL redir_stall_setup rsp=%b got=%h exp=%h", imem_rsp_valid, dut_vec, exp_vec());
    end
    advance();
    quiet(3);
    n = 0;
    while (!if_id_valid && n < 12) begin
      drive();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL redir_stall cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      end
      advance();
      n++;
    end
    checks++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'h200) begin
      errors++;
      $display("[TB] FAIL redir_stall_first valid=%b pc=%h exp pc=00000200", if_id_valid, if_id_pc);
    end
  endtask

  task automatic test_wrap();
    quiet(1);
    st_redir = 1'b1;
    st_rpc   = 32'hFFFF_FFFC;
    drive();
    advance();
    st_redir = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL wrap cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    quiet(2);
    for (int k = 0; k < 3; k++) begin
      drive();
      advance();
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec !== 105'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid got=%h exp=0 (outstanding %0d)", dut_vec, m_out);
    end
    model_reset();
    drive();
    advance();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL reset_restart cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_random();
    quiet(1);
    lat_hi    = 4;
    rand_data = 1'b1;
    for (int k = 0; k < 400; k++) begin
      st_ready = ($urandom_range(3, 0) != 0);
      st_stall = ($urandom_range(2, 0) == 0);
      st_redir = ($urandom_range(19, 0) == 0);
      st_rpc   = $urandom();
      drive();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      end
      advance();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    model_reset();
    test_reset();
    test_stream();
    test_stall();
    test_not_ready();
    test_redirect();
    test_redirect_stall_rsp();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog cyc=%0d exp=finish", cyc);
    $fatal(1, "[TB] timeout");
  end

endmodule
